// File: rtl/adder_mw_seq_pkg.sv
// rtl/adder_mw_seq_pkg.sv - shared word width and sequencer state encoding
package adder_mw_seq_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_mw_seq_if.sv
// rtl/adder_mw_seq_if.sv - request/result handshake bundle of the multi-word add/sub sequencer
interface adder_mw_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 32 * WORDS;

  logic         req_valid;
  logic         req_ready;
  logic         req_mode;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_carry;
  logic         res_overflow;
  logic         busy;

  modport master (
    output req_valid, req_mode, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_carry, res_overflow, busy
  );

  modport slave (
    input  req_valid, req_mode, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_carry, res_overflow, busy
  );

endinterface

// File: rtl/adder_mw_seq_adder_32.sv
// rtl/adder_mw_seq_adder_32.sv - 32-bit adder slice exposing carry-out and carry into bit 31
module adder_32
  import adder_mw_seq_pkg::*;
(
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  input  logic              i_cin,
  output logic [WORD_W-1:0] o_sum,
  output logic [1:0]        o_cout
);

  // Packs {carry out of bit 31, carry into bit 31, sum}.
  function automatic logic [WORD_W+1:0] add_slice(
    input logic [WORD_W-1:0] a,
    input logic [WORD_W-1:0] b,
    input logic              cin
  );
    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] p;
    logic [WORD_W-1:0] s;
    logic [WORD_W:0]   c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    for (int i = 0; i < WORD_W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s = p ^ c[WORD_W-1:0];
    return {c[WORD_W], c[WORD_W-1], s};
  endfunction

  logic [WORD_W+1:0] w_res;

  assign w_res  = add_slice(i_a, i_b, i_cin);
  assign o_sum  = w_res[WORD_W-1:0];
  assign o_cout = w_res[WORD_W+1:WORD_W];

endmodule

// File: rtl/adder_mw_seq.sv
// rtl/adder_mw_seq.sv - multi-word add/subtract sequencer, one 32-bit word per cycle LSW first
module adder_mw_seq
  import adder_mw_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  adder_mw_seq_if.slave bus
);

  localparam int W     = WORD_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_sum;
  logic              r_mode;
  logic              r_carry;
  logic              r_res_carry;
  logic              r_ovf;
  logic              r_valid;
  logic              r_req_ready;
  logic              r_busy;

  logic [WORD_W-1:0] w_b_word;
  logic [WORD_W-1:0] w_sum;
  logic [1:0]        w_cout;

  // Subtraction is a + ~b + 1; the +1 enters as the initial carry latched from mode.
  assign w_b_word = r_b[WORD_W-1:0] ^ {WORD_W{r_mode}};

  adder_32 u_adder (
    .i_a    (r_a[WORD_W-1:0]),
    .i_b    (w_b_word),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_mode      <= 1'b0;
      r_carry     <= 1'b0;
      r_res_carry <= 1'b0;
      r_ovf       <= 1'b0;
      r_valid     <= 1'b0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_a         <= bus.req_a;
            r_b         <= bus.req_b;
            r_mode      <= bus.req_mode;
            r_carry     <= bus.req_mode;
            r_idx       <= '0;
            r_state     <= S_RUN;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_RUN: begin
          // Operands shift down so the active word is always at bit 0; results enter at the top.
          r_a     <= r_a >> WORD_W;
          r_b     <= r_b >> WORD_W;
          r_sum   <= {w_sum, r_sum[W-1:WORD_W]};
          r_carry <= w_cout[1];
          r_idx   <= r_idx + 1'b1;
          if (r_idx == IDX_LAST) begin
            r_res_carry <= w_cout[1] ^ r_mode;
            r_ovf       <= w_cout[1] ^ w_cout[0];
            r_valid     <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_valid     <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_valid     <= 1'b0;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.res_valid    = r_valid;
  assign bus.res_sum      = r_sum;
  assign bus.res_carry    = r_res_carry;
  assign bus.res_overflow = r_ovf;
  assign bus.busy         = r_busy;

endmodule
